// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: definitions shared by the writeback stage, the register
// file and the forwarding logic.
//   selwb_e : encoding of the writeback source select
//   DW, AW, NREG : default data width, register address width and count
package wb_regfile_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  // Code 3 is reserved and falls back to the ALU result.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } selwb_e;

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// wb_mux: purely combinational writeback source select. The forwarding unit
// instantiates it as well, so both see the same value.
//   sel       in  2  writeback source select (selwb_e encoding)
//   alu_out   in  W  ALU result
//   load_data in  W  extended load data
//   pc_add4   in  W  link address
//   wb_data   out W  selected writeback value
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int W = wb_regfile_pkg::DW
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] alu_out,
  input  logic [W-1:0] load_data,
  input  logic [W-1:0] pc_add4,
  output logic [W-1:0] wb_data
);

  always_comb begin
    wb_data = alu_out;
    case (selwb_e'(sel))
      WB_LOAD: wb_data = load_data;
      WB_PC4:  wb_data = pc_add4;
      default: wb_data = alu_out;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage plus architectural register file.
// Selects the writeback value, writes it into the array on CLK, serves two
// combinational read ports with same-cycle write-to-read bypass, and counts
// committed writes.
// Build option: define R0_ZERO_EN to hardwire register 0 to zero (writes to
// it are dropped, not counted and not bypassed).
//   CLK, RSTN          clock, asynchronous active-low reset
//   SelWB_W            writeback source select
//   WEN_W              write enable, active-low
//   ALUOUT_W, LoadData_W, PCADD4_W  writeback sources
//   WA_W               write address
//   RA1, RA2 / RD1, RD2  read addresses / combinational read data
//   WBDATA_W           selected writeback value (for forwarding)
//   WCNT               committed-write counter, wraps silently
module wb_regfile #(
  parameter int DW   = wb_regfile_pkg::DW,
  parameter int NREG = wb_regfile_pkg::NREG,
  parameter int AW   = wb_regfile_pkg::AW,
  parameter int CW   = 32
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [1:0]    SelWB_W,
  input  logic          WEN_W,
  input  logic [DW-1:0] ALUOUT_W,
  input  logic [DW-1:0] LoadData_W,
  input  logic [DW-1:0] PCADD4_W,
  input  logic [AW-1:0] WA_W,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic [DW-1:0] WBDATA_W,
  output logic [CW-1:0] WCNT
);

  import wb_regfile_pkg::*;

  logic [DW-1:0] regs_reg [NREG];
  logic [CW-1:0] wcnt_reg;
  logic          r0_drop;
  logic          commit;
  logic [AW-1:0] ra      [2];
  logic [DW-1:0] rd      [2];

  wb_mux #(.W(DW)) u_wb_mux (
    .sel       (SelWB_W),
    .alu_out   (ALUOUT_W),
    .load_data (LoadData_W),
    .pc_add4   (PCADD4_W),
    .wb_data   (WBDATA_W)
  );

`ifdef R0_ZERO_EN
  assign r0_drop = (WA_W == '0);
`else
  assign r0_drop = 1'b0;
`endif

  // A write that actually lands in the array; it drives the array, the
  // counter and the bypass so the three always agree.
  assign commit = ~WEN_W & ~r0_drop;

  // With R0_ZERO_EN register 0 is never committed, so it holds its reset
  // value of zero for good.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else if (commit) begin
      regs_reg[WA_W] <= WBDATA_W;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)       wcnt_reg <= '0;
    else if (commit) wcnt_reg <= wcnt_reg + CW'(1);
  end

  assign WCNT  = wcnt_reg;
  assign ra[0] = RA1;
  assign ra[1] = RA2;

  // Bypass keys off commit, so a dropped R0 write is never forwarded and
  // reads of R0 return the hardwired zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rd[gi] = (commit && (WA_W == ra[gi])) ? WBDATA_W : regs_reg[ra[gi]];
  end

  assign RD1 = rd[0];
  assign RD2 = rd[1];

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed bench for wb_regfile. A full-width instance and a
// CW=4 instance share all inputs; a reference register model predicts every
// output, expectations go through a scoreboard queue.
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [1:0]  sel;
  logic        wen;
  logic [31:0] alu, ld, pc;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] rd1, rd2, wbd, wcnt;
  logic [31:0] rd1_w, rd2_w, wbd_w;
  logic [3:0]  wcnt_w;

  always #5 CLK = ~CLK;

  wb_regfile #(.CW(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .SelWB_W(sel), .WEN_W(wen),
    .ALUOUT_W(alu), .LoadData_W(ld), .PCADD4_W(pc), .WA_W(wa),
    .RA1(ra1), .RA2(ra2), .RD1(rd1), .RD2(rd2), .WBDATA_W(wbd), .WCNT(wcnt)
  );

  wb_regfile #(.CW(4)) dut_w (
    .CLK(CLK), .RSTN(RSTN), .SelWB_W(sel), .WEN_W(wen),
    .ALUOUT_W(alu), .LoadData_W(ld), .PCADD4_W(pc), .WA_W(wa),
    .RA1(ra1), .RA2(ra2), .RD1(rd1_w), .RD2(rd2_w), .WBDATA_W(wbd_w), .WCNT(wcnt_w)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  function automatic logic [31:0] m_wb();
    case (sel)
      2'd1:    return ld;
      2'd2:    return pc;
      default: return alu;
    endcase
  endfunction

  function automatic bit m_commit();
`ifdef R0_ZERO_EN
    return !wen && (wa != 5'd0);
`else
    return !wen;
`endif
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (m_commit() && wa == a) return m_wb();
    return m_regs[a];
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t x;
    x = sb.pop_front();
    total++;
    assert (obs === x.exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
    end
    $display("t=%0t chk %s obs=%h exp=%h", $time, x.tag, obs, x.exp);
  endtask

  task automatic drive(input logic [1:0] s, input logic w, input logic [4:0] a,
                       input logic [31:0] d_alu, input logic [31:0] d_ld,
                       input logic [31:0] d_pc, input logic [4:0] r1,
                       input logic [4:0] r2);
    sel = s; wen = w; wa = a; alu = d_alu; ld = d_ld; pc = d_pc;
    ra1 = r1; ra2 = r2;
  endtask

  // Combinational outputs of both instances against the model.
  task automatic check_ports(input string tag);
    push({tag, "_wb"},    m_wb());
    push({tag, "_rd1"},   m_rd(ra1));
    push({tag, "_rd2"},   m_rd(ra2));
    push({tag, "_rd1_w"}, m_rd(ra1));
    #1;
    pop_check(wbd);
    pop_check(rd1);
    pop_check(rd2);
    pop_check(rd1_w);
  endtask

  task automatic check_cnt(input string tag);
    push({tag, "_wcnt"},   m_cnt);
    push({tag, "_wcnt_w"}, {28'd0, m_cnt[3:0]});
    pop_check(wcnt);
    pop_check({28'd0, wcnt_w});
  endtask

  task automatic tick();
    if (RSTN && m_commit()) begin
      m_regs[wa] = m_wb();
      m_cnt      = m_cnt + 32'd1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0;
  endtask

  initial begin
    model_reset();
    RSTN = 1'b0;
    drive(2'd0, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
    #3;
    check_ports("rst");
    check_cnt("rst");
    @(negedge CLK);
    RSTN = 1'b1;

    // Writeback source select, including the reserved code.
    for (int s = 0; s < 4; s++) begin
      drive(2'(s), 1'b0, 5'd3, 32'hA, 32'hB, 32'hC, 5'd3, 5'd4);
      check_ports($sformatf("mux%0d_byp", s));
      tick();
      drive(2'(s), 1'b1, 5'd3, 32'hA, 32'hB, 32'hC, 5'd3, 5'd4);
      check_ports($sformatf("mux%0d_reg", s));
    end
    check_cnt("mux");

    // Bypass to both ports in the write cycle, then from the array.
    drive(2'd0, 1'b0, 5'd7, 32'hDEADBEEF, 32'h1, 32'h2, 5'd7, 5'd7);
    check_ports("byp_pre");
    tick();
    drive(2'd0, 1'b1, 5'd7, 32'hDEADBEEF, 32'h1, 32'h2, 5'd7, 5'd7);
    check_ports("byp_post");

    // Write disabled for three edges.
    drive(2'd0, 1'b1, 5'd9, 32'h55, 32'h55, 32'h55, 5'd9, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ports($sformatf("wdis%0d", i));
    end
    check_cnt("wdis");

    // Register 0 write.
    drive(2'd0, 1'b0, 5'd0, 32'h99, 32'h0, 32'h0, 5'd0, 5'd0);
    check_ports("r0_dur");
    tick();
    drive(2'd0, 1'b1, 5'd0, 32'h99, 32'h0, 32'h0, 5'd0, 5'd0);
    check_ports("r0_aft");
    check_cnt("r0");

    // Mixed random traffic.
    for (int i = 0; i < 20; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), a,
            $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
            (i % 2 == 0) ? a : 5'($urandom_range(0, 31)));
      check_ports($sformatf("rnd%0d", i));
      tick();
    end
    check_cnt("rnd");

    // Asynchronous reset mid-run clears the array at once.
    drive(2'd0, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd6);
    tick();
    drive(2'd0, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd6);
    check_ports("pre_rst");
    #2;
    RSTN = 1'b0;
    model_reset();
    check_ports("mid_rst");
    check_cnt("mid_rst");
    // A write presented while reset is held is lost.
    drive(2'd0, 1'b0, 5'd5, 32'h777, 32'h0, 32'h0, 5'd1, 5'd6);
    tick();
    drive(2'd0, 1'b1, 5'd5, 32'h777, 32'h0, 32'h0, 5'd5, 5'd6);
    check_ports("rst_lost");
    @(negedge CLK);
    RSTN = 1'b1;

    // 17 writes: the 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      drive(2'd0, 1'b0, 5'(i % 8 + 1), 32'(i), 32'h0, 32'h0, 5'd1, 5'd2);
      tick();
    end
    drive(2'd0, 1'b1, 5'd1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2);
    check_ports("wrap");
    check_cnt("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
